pipeline_ctrl: RTL and testbench

- Hazard and stall/flush sequencer for the 5-stage pipeline (IF, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Detects load-use hazards, applies branch/jump redirect flushes and freezes the pipeline during multi-cycle data-memory accesses.
- Drives the enable and flush inputs of every pipeline register and the PC.
- Keeps a stall-cycle counter and a sticky memory-timeout error.

---
 rtl/pipeline_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl
//   Hazard and stall/flush sequencer for a 5-stage pipeline
//   (IF, IF/ID, ID/EX, EX/MEM, MEM/WB). It detects load-use hazards, applies
//   branch/jump redirect flushes, and freezes the whole pipeline while a
//   data-memory access is waiting for its acknowledge.
//
// Parameters
//   FLUSH_CYCLES : cycles IF/ID is flushed per redirect (1..4)
//   MEM_TIMEOUT  : max stalled cycles waiting for dmem ack before error (2..255)
//   CNT_W        : width of the saturating stall-cycle counter
//
// Ports
//   clk_i, rst_i        : clock (rising edge) / synchronous active-high reset
//   id_rs1_i, id_rs2_i  : source registers of the instruction in IF/ID
//   id_uses_rs1_i/rs2_i : IF/ID instruction actually reads rs1 / rs2
//   ex_rd_i             : destination of the instruction in ID/EX
//   ex_mem_read_i       : ID/EX instruction is a load
//   redirect_i          : EX resolved a taken branch/jump this cycle
//   dmem_req_i          : MEM stage has a load/store outstanding
//   dmem_ack_i          : data memory completes the request this cycle
//   pc_en_o .. mem_wb_en_o : pipeline register / PC enables and flushes
//   mem_err_o           : sticky memory-timeout error
//   stall_cnt_o         : cycles with pc_en_o=0 since reset (saturating)
// ---------------------------------------------------------------------------
module pipeline_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int MEM_TIMEOUT  = 64,
    parameter int CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_mem_read_i,
    input  logic             redirect_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             pc_en_o,
    output logic             if_id_en_o,
    output logic             if_id_flush_o,
    output logic             id_ex_en_o,
    output logic             id_ex_flush_o,
    output logic             ex_mem_en_o,
    output logic             mem_wb_en_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2,
        HALT     = 2'd3
    } state_t;

    // Flush count loaded on a redirect: the redirect cycle itself flushes
    // once, the REDIRECT state covers the remaining FLUSH_CYCLES-1 cycles.
    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_CYCLES - 1);
    // The wait counter holds the number of stalled cycles already seen; the
    // stalled cycle that would bring it to MEM_TIMEOUT trips the error.
    localparam logic [7:0] WAIT_LIMIT   = 8'(MEM_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [1:0]        flush_q, flush_d;
    logic [7:0]        wait_q,  wait_d;
    logic              err_q,   err_d;
    logic [CNT_W-1:0]  stall_q;

    logic mem_stall;
    logic rs1_hit, rs2_hit;
    logic load_use;

    assign mem_stall = dmem_req_i & ~dmem_ack_i;
    assign rs1_hit   = id_uses_rs1_i & (id_rs1_i == ex_rd_i);
    assign rs2_hit   = id_uses_rs2_i & (id_rs2_i == ex_rd_i);
    // x0 is never a real dependency.
    assign load_use  = ex_mem_read_i & (ex_rd_i != 5'd0) & (rs1_hit | rs2_hit);

    // -----------------------------------------------------------------------
    // Next-state and output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        flush_d       = flush_q;
        wait_d        = wait_q;
        err_d         = err_q;
        pc_en_o       = 1'b1;
        if_id_en_o    = 1'b1;
        if_id_flush_o = 1'b0;
        id_ex_en_o    = 1'b1;
        id_ex_flush_o = 1'b0;
        ex_mem_en_o   = 1'b1;
        mem_wb_en_o   = 1'b1;

        if (rst_i) begin
            // Hold every register and push NOPs/bubbles while in reset.
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            if_id_flush_o = 1'b1;
            id_ex_en_o    = 1'b0;
            id_ex_flush_o = 1'b1;
            ex_mem_en_o   = 1'b0;
            mem_wb_en_o   = 1'b0;
        end else if (state_q == HALT) begin
            // Dead until reset; a late ack must not restart anything.
            pc_en_o     = 1'b0;
            if_id_en_o  = 1'b0;
            id_ex_en_o  = 1'b0;
            ex_mem_en_o = 1'b0;
            mem_wb_en_o = 1'b0;
        end else if (mem_stall) begin
            // Full freeze: nothing moves, nothing is flushed. A coincident
            // redirect stays pending in EX and is applied on the ack cycle.
            pc_en_o     = 1'b0;
            if_id_en_o  = 1'b0;
            id_ex_en_o  = 1'b0;
            ex_mem_en_o = 1'b0;
            mem_wb_en_o = 1'b0;
            if (state_q == MEM_WAIT) begin
                wait_d = wait_q + 8'd1;
                if (wait_q >= WAIT_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = HALT;
                end
            end else begin
                // Flush counter is deliberately held so an interrupted
                // REDIRECT sequence resumes after the ack.
                state_d = MEM_WAIT;
                wait_d  = 8'd1;
            end
        end else begin
            // RUN, REDIRECT, or the ack cycle of MEM_WAIT.
            wait_d = 8'd0;
            if (redirect_i) begin
                if_id_flush_o = 1'b1;
                id_ex_flush_o = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    state_d = REDIRECT;
                    flush_d = FLUSH_RELOAD;
                end else begin
                    state_d = RUN;
                    flush_d = 2'd0;
                end
            end else if (state_q == REDIRECT) begin
                // IF/ID still holds wrong-path fetches; it is NOP'd, so any
                // apparent load-use against it is meaningless.
                if_id_flush_o = 1'b1;
                if (flush_q <= 2'd1) begin
                    flush_d = 2'd0;
                    state_d = RUN;
                end else begin
                    flush_d = flush_q - 2'd1;
                end
            end else begin
                if (load_use) begin
                    // One bubble: next cycle ID/EX holds it, clearing the hazard.
                    pc_en_o       = 1'b0;
                    if_id_en_o    = 1'b0;
                    id_ex_flush_o = 1'b1;
                end
                // Leaving MEM_WAIT resumes any interrupted flush sequence.
                if (state_q == MEM_WAIT && flush_q != 2'd0)
                    state_d = REDIRECT;
                else
                    state_d = RUN;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            flush_q <= 2'd0;
            wait_q  <= 8'd0;
            err_q   <= 1'b0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
            if (!pc_en_o && stall_q != {CNT_W{1'b1}})
                stall_q <= stall_q + 1'b1;
        end
    end

    assign mem_err_o   = err_q;
    assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, mrd, redir, req, ack;

    // DUT A: three-cycle flush, timeout long enough for the 5-cycle wait test.
    logic        a_pc, a_ifen, a_iffl, a_exen, a_exfl, a_mmen, a_wben, a_err;
    logic [31:0] a_cnt;
    // DUT B: single-cycle flush, short timeout, narrow counter for saturation.
    logic        b_pc, b_ifen, b_iffl, b_exen, b_exfl, b_mmen, b_wben, b_err;
    logic [3:0]  b_cnt;

    pipeline_ctrl #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(8), .CNT_W(32)) dut_a (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_uses_rs1_i(use1), .id_uses_rs2_i(use2),
        .ex_rd_i(rd), .ex_mem_read_i(mrd), .redirect_i(redir),
        .dmem_req_i(req), .dmem_ack_i(ack),
        .pc_en_o(a_pc), .if_id_en_o(a_ifen), .if_id_flush_o(a_iffl),
        .id_ex_en_o(a_exen), .id_ex_flush_o(a_exfl), .ex_mem_en_o(a_mmen),
        .mem_wb_en_o(a_wben), .mem_err_o(a_err), .stall_cnt_o(a_cnt)
    );

    pipeline_ctrl #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(4), .CNT_W(4)) dut_b (
        .clk_i(clk), .rst_i(rst),
        .id_rs1_i(rs1), .id_rs2_i(rs2), .id_uses_rs1_i(use1), .id_uses_rs2_i(use2),
        .ex_rd_i(rd), .ex_mem_read_i(mrd), .redirect_i(redir),
        .dmem_req_i(req), .dmem_ack_i(ack),
        .pc_en_o(b_pc), .if_id_en_o(b_ifen), .if_id_flush_o(b_iffl),
        .id_ex_en_o(b_exen), .id_ex_flush_o(b_exfl), .ex_mem_en_o(b_mmen),
        .mem_wb_en_o(b_wben), .mem_err_o(b_err), .stall_cnt_o(b_cnt)
    );

    // Control vector order: {pc_en, if_id_en, if_id_flush, id_ex_en,
    //                        id_ex_flush, ex_mem_en, mem_wb_en}
    wire [6:0] a_vec = {a_pc, a_ifen, a_iffl, a_exen, a_exfl, a_mmen, a_wben};
    wire [6:0] b_vec = {b_pc, b_ifen, b_iffl, b_exen, b_exfl, b_mmen, b_wben};

    localparam logic [6:0] V_NORM = 7'b1101011;
    localparam logic [6:0] V_FRZ  = 7'b0000000;
    localparam logic [6:0] V_RST  = 7'b0010100;
    localparam logic [6:0] V_RDR  = 7'b1111111;
    localparam logic [6:0] V_RDS  = 7'b1111011;
    localparam logic [6:0] V_LU   = 7'b0001111;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then changed 1ns after the edge and
    // outputs sampled 1ns later, well away from the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
        use1 = 1'b0; use2 = 1'b0; mrd = 1'b0;
        redir = 1'b0; req = 1'b0; ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic set_load_use();
        mrd = 1'b1; rd = 5'd5; rs1 = 5'd5; use1 = 1'b1;
    endtask

    initial begin
        // ---- reset ----
        rst = 1'b1;
        idle_inputs();
        #1;
        chk("rst_vec_a", 32'(a_vec), 32'(V_RST));
        tick();
        #1;
        chk("rst_vec_held", 32'(a_vec), 32'(V_RST));
        chk("rst_cnt", a_cnt, 32'd0);
        chk("rst_err", 32'(a_err), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_norm", 32'(a_vec), 32'(V_NORM));

        // ---- load-use: lw x5; add x6,x5,x1 ----
        tick();
        set_load_use();
        #1;
        chk("lu_bubble", 32'(a_vec), 32'(V_LU));
        tick();
        mrd = 1'b0;                       // ID/EX now holds the bubble
        #1;
        chk("lu_after", 32'(a_vec), 32'(V_NORM));
        chk("lu_cnt", a_cnt, 32'd1);

        // ---- rd = x0 never stalls ----
        set_load_use(); rd = 5'd0; rs1 = 5'd0;
        #1;
        chk("lu_x0", 32'(a_vec), 32'(V_NORM));
        tick();
        // ---- rs1 matches but not read ----
        set_load_use(); use1 = 1'b0;
        #1;
        chk("lu_nouse", 32'(a_vec), 32'(V_NORM));
        tick();
        mrd = 1'b0;
        #1;
        chk("lu_nostall_cnt", a_cnt, 32'd1);
        // ---- rs2 path ----
        mrd = 1'b1; rd = 5'd7; rs2 = 5'd7; use2 = 1'b1; rs1 = 5'd3; use1 = 1'b1;
        #1;
        chk("lu_rs2", 32'(a_vec), 32'(V_LU));
        tick();
        idle_inputs();
        #1;
        chk("lu_rs2_cnt", a_cnt, 32'd2);

        // ---- redirect pulse, FLUSH_CYCLES=3 on A, 1 on B ----
        do_reset();
        redir = 1'b1;
        #1;
        chk("rdr_c1_a", 32'(a_vec), 32'(V_RDR));
        chk("rdr_c1_b", 32'(b_vec), 32'(V_RDR));
        tick();
        redir = 1'b0;
        #1;
        chk("rdr_c2_a", 32'(a_vec), 32'(V_RDS));
        chk("rdr_c2_b", 32'(b_vec), 32'(V_NORM));
        tick();
        set_load_use();                   // ignored while IF/ID is being NOP'd
        #1;
        chk("rdr_c3_a_lu_ign", 32'(a_vec), 32'(V_RDS));
        tick();
        idle_inputs();
        #1;
        chk("rdr_c4_a", 32'(a_vec), 32'(V_NORM));

        // ---- mem stall 5 cycles with load-use pending, then ack ----
        do_reset();
        set_load_use();
        req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("mem_frz_%0d", i), 32'(a_vec), 32'(V_FRZ));
            tick();
        end
        ack = 1'b1;
        #1;
        chk("mem_ack_lu", 32'(a_vec), 32'(V_LU));
        tick();
        idle_inputs();
        #1;
        chk("mem_after", 32'(a_vec), 32'(V_NORM));
        chk("mem_cnt", a_cnt, 32'd6);
        chk("mem_no_err", 32'(a_err), 32'd0);

        // ---- redirect coincident with mem stall ----
        do_reset();
        redir = 1'b1; req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("rdm_frz_%0d", i), 32'(a_vec), 32'(V_FRZ));
            tick();
        end
        ack = 1'b1;
        #1;
        chk("rdm_ack", 32'(a_vec), 32'(V_RDR));
        tick();
        idle_inputs();
        #1;
        chk("rdm_c2", 32'(a_vec), 32'(V_RDS));
        tick();
        #1;
        chk("rdm_c3", 32'(a_vec), 32'(V_RDS));
        tick();
        #1;
        chk("rdm_c4", 32'(a_vec), 32'(V_NORM));
        chk("rdm_cnt", a_cnt, 32'd3);

        // ---- timeout on B (MEM_TIMEOUT=4) ----
        do_reset();
        req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("to_frz_%0d", i), 32'(b_vec), 32'(V_FRZ));
            chk($sformatf("to_err_pre_%0d", i), 32'(b_err), 32'd0);
            tick();
        end
        #1;
        chk("to_err_set", 32'(b_err), 32'd1);
        ack = 1'b1;                       // late ack must be ignored
        #1;
        chk("to_halt_ack", 32'(b_vec), 32'(V_FRZ));
        tick();
        req = 1'b0; ack = 1'b0;
        #1;
        chk("to_halt_hold", 32'(b_vec), 32'(V_FRZ));
        chk("to_err_sticky", 32'(b_err), 32'd1);
        // 5 stall cycles counted so far; run well past 15 to saturate.
        for (int i = 0; i < 15; i++) tick();
        #1;
        chk("to_cnt_sat", 32'(b_cnt), 32'hF);
        rst = 1'b1;
        #1;
        chk("to_rst_vec", 32'(b_vec), 32'(V_RST));
        tick();
        rst = 1'b0;
        #1;
        chk("to_rst_err", 32'(b_err), 32'd0);
        chk("to_rst_cnt", 32'(b_cnt), 32'd0);
        chk("to_rst_run", 32'(b_vec), 32'(V_NORM));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Safety net so the bench always ends by itself.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
